// File: rtl/axi_burst_reader_pkg.sv
// Shared FSM state, AXI AR constants and the per-burst length rule for axi_burst_reader.
package axi_burst_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic [1:0]  BURST_INCR  = 2'b01;
  localparam logic        AR_LOCK     = 1'b0;
  localparam logic [3:0]  AR_CACHE    = 4'b0011;
  localparam logic [2:0]  AR_PROT     = 3'b000;
  localparam int unsigned BOUNDARY_4K = 4096;

  // Beats in the next burst: bounded by what is left, the burst cap and the next 4 KB page edge.
  function automatic int unsigned burst_beats(input int unsigned remaining,
                                              input int unsigned addr_lo,
                                              input int unsigned size_log2,
                                              input int unsigned max_len);
    int unsigned beats;
    beats = (BOUNDARY_4K - addr_lo) >> size_log2;
    if (max_len < beats) beats = max_len;
    if (remaining < beats) beats = remaining;
    return beats;
  endfunction

endpackage

// File: rtl/axi_burst_reader.sv
// Splits one linear read command into 4 KB-safe AXI4 INCR bursts and streams the data back.
// AR rises 1 cycle after accept or burst end, done 1 cycle after the last beat; R backpressure is out_ready passed through.
module axi_burst_reader
  import axi_burst_reader_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDR_WIDTH    = 32,
  parameter int ID_WIDTH      = 4,
  parameter int ARID_VALUE    = 0,
  parameter int MAX_BURST_LEN = 16,
  parameter int CMD_LEN_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,

  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ADDR_WIDTH-1:0]    cmd_addr,
  input  logic [CMD_LEN_WIDTH-1:0] cmd_len,

  output logic [ID_WIDTH-1:0]      m_axi_arid,
  output logic [ADDR_WIDTH-1:0]    m_axi_araddr,
  output logic [7:0]               m_axi_arlen,
  output logic [2:0]               m_axi_arsize,
  output logic [1:0]               m_axi_arburst,
  output logic                     m_axi_arlock,
  output logic [3:0]               m_axi_arcache,
  output logic [2:0]               m_axi_arprot,
  output logic                     m_axi_arvalid,
  input  logic                     m_axi_arready,

  input  logic [ID_WIDTH-1:0]      m_axi_rid,
  input  logic [DATA_WIDTH-1:0]    m_axi_rdata,
  input  logic [1:0]               m_axi_rresp,
  input  logic                     m_axi_rlast,
  input  logic                     m_axi_rvalid,
  output logic                     m_axi_rready,

  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready,

  output logic                     done,
  output logic                     err
);

  localparam int SIZE_LOG2 = $clog2(DATA_WIDTH / 8);
  localparam int REM_W     = CMD_LEN_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'((1 << SIZE_LOG2) - 1);

  function automatic logic [7:0] next_arlen(input logic [11:0] addr_lo, input logic [REM_W-1:0] rem);
    return 8'(burst_beats(32'(rem), 32'(addr_lo), SIZE_LOG2, MAX_BURST_LEN) - 1);
  endfunction

  state_t                  state_q, state_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              arlen_q, arlen_d;
  logic [REM_W-1:0]        rem_q, rem_d;
  logic [7:0]              burst_cnt_q, burst_cnt_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic                    in_data;
  logic                    r_hs;
  logic                    beat_err;
  logic                    unused_rid;

  assign unused_rid = ^m_axi_rid;

  assign in_data  = (state_q == ST_DATA);
  assign r_hs     = in_data && m_axi_rvalid && out_ready;
  // rlast is only cross-checked; beat counting follows burst_cnt.
  assign beat_err = (m_axi_rresp != 2'b00) || (m_axi_rlast != (burst_cnt_q == 8'd0));

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    arvalid_d   = arvalid_q;
    addr_d      = addr_q;
    arlen_d     = arlen_q;
    rem_d       = rem_q;
    burst_cnt_d = burst_cnt_q;
    done_d      = 1'b0;
    err_d       = err_q;

    case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          addr_d      = cmd_addr & ALIGN_MASK;
          rem_d       = REM_W'(cmd_len) + REM_W'(1);
          err_d       = 1'b0;
          arvalid_d   = 1'b1;
          arlen_d     = next_arlen(addr_d[11:0], rem_d);
          state_d     = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (m_axi_arready) begin
          arvalid_d   = 1'b0;
          burst_cnt_d = arlen_q;
          addr_d      = addr_q + ((ADDR_WIDTH'(arlen_q) + ADDR_WIDTH'(1)) << SIZE_LOG2);
          rem_d       = rem_q - (REM_W'(arlen_q) + REM_W'(1));
          state_d     = ST_DATA;
        end
      end
      ST_DATA: begin
        if (r_hs) begin
          if (beat_err) err_d = 1'b1;
          if (burst_cnt_q == 8'd0) begin
            if (rem_q == '0) begin
              done_d      = 1'b1;
              cmd_ready_d = 1'b1;
              state_d     = ST_IDLE;
            end else begin
              arvalid_d = 1'b1;
              arlen_d   = next_arlen(addr_q[11:0], rem_q);
              state_d   = ST_ADDR;
            end
          end else begin
            burst_cnt_d = burst_cnt_q - 8'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      arvalid_q   <= 1'b0;
      addr_q      <= '0;
      arlen_q     <= '0;
      rem_q       <= '0;
      burst_cnt_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      arvalid_q   <= arvalid_d;
      addr_q      <= addr_d;
      arlen_q     <= arlen_d;
      rem_q       <= rem_d;
      burst_cnt_q <= burst_cnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign m_axi_arid    = ID_WIDTH'(ARID_VALUE);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arsize  = 3'(SIZE_LOG2);
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_arlock  = AR_LOCK;
  assign m_axi_arcache = AR_CACHE;
  assign m_axi_arprot  = AR_PROT;
  assign m_axi_arvalid = arvalid_q;

  assign m_axi_rready  = in_data && out_ready;
  assign out_valid     = in_data && m_axi_rvalid;
  assign out_data      = m_axi_rdata;
  assign out_last      = out_valid && (burst_cnt_q == 8'd0) && (rem_q == '0);
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_axi_burst_reader.sv
// Drives axi_burst_reader against a behavioural AXI RAM slave and checks bursts/stream/done against a command-level model.
module tb_axi_burst_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_len;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready   = 1'b0;
  logic [3:0]  rid       = 4'd0;
  logic [63:0] rdata     = 64'd0;
  logic [1:0]  rresp     = 2'd0;
  logic        rlast     = 1'b0;
  logic        rvalid    = 1'b0;
  logic        rready;
  logic [63:0] out_data;
  logic        out_last, out_valid;
  logic        out_ready = 1'b1;
  logic        done, err;

  axi_burst_reader #(
    .DATA_WIDTH(64), .ADDR_WIDTH(32), .ID_WIDTH(4), .ARID_VALUE(0),
    .MAX_BURST_LEN(16), .CMD_LEN_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache), .m_axi_arprot(arprot),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .done(done), .err(err)
  );

  typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;
  typedef struct { logic [63:0] data; logic last; } beat_t;
  typedef struct {
    logic [31:0] addr; int len; int mode; int err_beat; int bad_last; logic exp_err;
  } vec_t;

  int    checks = 0;
  int    errors = 0;
  ar_t   ar_q[$];
  beat_t out_q[$];

  // stimulus knobs (mode 0: always ready, 1: random, 2: out_ready toggles)
  int mode = 0, err_beat = -1, bad_last = 0;

  // monitor state, owned by tick()
  int          beats_seen = 0, cmd_total = 0, done_cnt = 0;
  logic        done_err = 1'b0;
  logic        chk_arv_next = 1'b0, chk_done_next = 1'b0, prev_arpend = 1'b0;
  logic [31:0] prev_araddr = 32'd0;
  logic [7:0]  prev_arlen = 8'd0;
  logic        ar_hs_s = 1'b0, r_hs_s = 1'b0;
  logic [31:0] ar_addr_s = 32'd0;
  logic [7:0]  ar_len_s = 8'd0;

  // slave state
  logic        sl_act = 1'b0;
  logic [31:0] sl_addr = 32'd0;
  logic [7:0]  sl_len = 8'd0;
  int          sl_idx = 0;

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {a ^ 32'hC0DE_F00D, a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural AXI RAM slave: reacts one cycle after handshakes seen by the monitor.
  always @(posedge clk) begin
    logic hold;
    #1;
    if (rst) begin
      sl_act = 1'b0; sl_idx = 0; arready = 1'b0; rvalid = 1'b0;
      rlast = 1'b0; rresp = 2'd0; out_ready = 1'b1;
    end else begin
      hold = rvalid && !r_hs_s && sl_act;
      if (ar_hs_s) begin
        sl_act = 1'b1; sl_addr = ar_addr_s; sl_len = ar_len_s; sl_idx = 0;
      end else if (r_hs_s) begin
        if (sl_idx == int'(sl_len)) sl_act = 1'b0;
        else sl_idx++;
      end
      if (mode == 0) begin
        arready   = 1'b1;
        out_ready = 1'b1;
      end else begin
        arready   = ($urandom_range(0, 99) < 60);
        out_ready = (mode == 2) ? !out_ready : ($urandom_range(0, 99) < 65);
      end
      rvalid = sl_act && (hold || mode == 0 || $urandom_range(0, 99) < 70);
      rdata  = mem_word(sl_addr + (32'(sl_idx) << 3));
      rlast  = (bad_last == 0) ? (sl_idx == int'(sl_len)) : (bad_last == 2);
      rresp  = (beats_seen == err_beat) ? 2'b10 : 2'b00;
    end
  end

  // Advance to the next falling edge and run all per-cycle protocol checks there.
  task automatic tick();
    logic ar_hs, r_hs, o_hs;
    @(negedge clk);
    if (rst) begin
      chk_arv_next = 1'b0; chk_done_next = 1'b0; prev_arpend = 1'b0;
      ar_hs_s = 1'b0; r_hs_s = 1'b0;
      return;
    end
    if (chk_arv_next) check("ar_next_cycle", arvalid, 1);
    if (chk_done_next) begin
      check("done_latency", done, 1);
      check("ready_with_done", cmd_ready, 1);
    end
    if (prev_arpend) begin
      check("ar_hold_valid", arvalid, 1);
      check("ar_hold_addr", araddr, prev_araddr);
      check("ar_hold_len", arlen, prev_arlen);
    end
    if (rvalid) begin
      check("rready_mirror", rready, out_ready);
      check("out_valid_pass", out_valid, 1);
      check("out_data_pass", out_data, rdata);
    end
    ar_hs = arvalid && arready;
    r_hs  = rvalid && rready;
    o_hs  = out_valid && out_ready;
    if (ar_hs) begin
      check("one_outstanding", sl_act, 0);
      check("ar_size", arsize, 3);
      check("ar_burst", arburst, 1);
      ar_q.push_back('{araddr, arlen});
    end
    if (o_hs) begin
      out_q.push_back('{out_data, out_last});
      beats_seen++;
    end
    chk_done_next = o_hs && (beats_seen == cmd_total);
    chk_arv_next  = r_hs && (sl_idx == int'(sl_len)) && (beats_seen < cmd_total);
    if (done) begin
      done_cnt++;
      done_err = err;
    end
    prev_arpend = arvalid && !arready;
    prev_araddr = araddr;
    prev_arlen  = arlen;
    ar_hs_s = ar_hs; r_hs_s = r_hs; ar_addr_s = araddr; ar_len_s = arlen;
  endtask

  int done_start = 0;

  task automatic start_cmd(input logic [31:0] a, input int len);
    int n = 0;
    while (!cmd_ready && n < 200) begin tick(); n++; end
    check("cmd_ready_wait", cmd_ready, 1);
    cmd_addr = a; cmd_len = 16'(len); cmd_valid = 1'b1;
    ar_q.delete(); out_q.delete();
    beats_seen = 0; cmd_total = len + 1; done_start = done_cnt;
    tick();
    cmd_valid = 1'b0;
    check("ar_after_accept", arvalid, 1);
    check("busy_not_ready", cmd_ready, 0);
  endtask

  task automatic finish_cmd(input logic [31:0] a, input int len, input logic exp_err);
    int n = 0, k = 0, rem;
    logic [31:0] base, ba;
    int b, b4k;
    while (done_cnt == done_start && n < 3000) begin tick(); n++; end
    check("done_seen", done_cnt != done_start, 1);
    if (done_cnt == done_start) begin
      rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
      return;
    end
    tick(); tick();
    check("done_once", done_cnt - done_start, 1);
    check("err_flag", done_err, exp_err);
    // Expected burst list from the command alone.
    base = a & ~32'h7;
    ba   = base;
    rem  = len + 1;
    while (rem > 0) begin
      b   = (rem > 16) ? 16 : rem;
      b4k = (4096 - int'(ba % 4096)) / 8;
      if (b > b4k) b = b4k;
      if (k < ar_q.size()) begin
        check("ar_addr", ar_q[k].addr, ba);
        check("ar_len", ar_q[k].len, b - 1);
      end
      ba  += 32'(b * 8);
      rem -= b;
      k++;
    end
    check("ar_count", ar_q.size(), k);
    check("beat_count", out_q.size(), len + 1);
    for (int i = 0; i < out_q.size() && i <= len; i++) begin
      check("beat_data", out_q[i].data, mem_word(base + 32'(i * 8)));
      check("beat_last", out_q[i].last, (i == len));
    end
  endtask

  task automatic run_cmd(input vec_t v);
    mode = v.mode; err_beat = v.err_beat; bad_last = v.bad_last;
    start_cmd(v.addr, v.len);
    finish_cmd(v.addr, v.len, v.exp_err);
  endtask

  vec_t vecs[10];

  initial begin
    int n;
    vec_t r;
    vecs[0] = '{32'h0000_1000,  3, 0, -1, 0, 1'b0};  // basic
    vecs[1] = '{32'h0000_0000, 39, 0, -1, 0, 1'b0};  // split 15/15/7
    vecs[2] = '{32'h0000_0FF0,  7, 0, -1, 0, 1'b0};  // 4 KB crossing
    vecs[3] = '{32'h0000_3000,  9, 2, -1, 0, 1'b0};  // toggling out_ready
    vecs[4] = '{32'h0000_4000,  3, 0,  1, 0, 1'b1};  // rresp error on beat 2
    vecs[5] = '{32'h0000_5008,  0, 1, -1, 0, 1'b0};  // single beat
    vecs[6] = '{32'h0000_6005,  5, 1, -1, 0, 1'b0};  // unaligned start
    vecs[7] = '{32'h0000_7000, 20, 1, -1, 1, 1'b1};  // rlast never asserted
    vecs[8] = '{32'h0000_8000,  4, 0, -1, 2, 1'b1};  // rlast on every beat
    vecs[9] = '{32'h0000_1F80, 50, 1, -1, 0, 1'b0};  // crossing mid-command

    cmd_valid = 1'b0; cmd_addr = 32'd0; cmd_len = 16'd0;
    rst = 1'b1;
    repeat (3) tick();
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_arvalid", arvalid, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_araddr", araddr, 0);
    check("rst_arlen", arlen, 0);
    check("rst_arcache", arcache, 4'b0011);
    check("rst_arlock", arlock, 0);
    check("rst_arprot", arprot, 0);
    check("rst_out_valid", out_valid, 0);
    rst = 1'b0;
    tick();
    check("ready_after_reset", cmd_ready, 1);

    for (int i = 0; i < 10; i++) run_cmd(vecs[i]);

    for (int i = 0; i < 16; i++) begin
      r.addr     = ($urandom_range(0, 15) << 12) | $urandom_range(0, 4095);
      r.len      = $urandom_range(0, 70);
      r.mode     = $urandom_range(0, 2);
      r.err_beat = ($urandom_range(0, 3) == 0) ? $urandom_range(0, r.len) : -1;
      r.bad_last = 0;
      r.exp_err  = (r.err_beat >= 0);
      run_cmd(r);
    end

    // Reset in the middle of the data phase, then a clean command.
    mode = 0; err_beat = -1; bad_last = 0;
    start_cmd(32'h0000_2000, 7);
    n = 0;
    while (beats_seen < 2 && n < 200) begin tick(); n++; end
    check("mid_beats_reached", beats_seen >= 2, 1);
    rst = 1'b1;
    tick();
    check("mid_rst_arvalid", arvalid, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_out_valid", out_valid, 0);
    rst = 1'b0;
    tick();
    check("mid_post_ready", cmd_ready, 1);
    check("mid_post_arvalid", arvalid, 0);
    check("mid_post_done", done, 0);
    check("mid_post_err", err, 0);
    r = '{32'h0000_2000, 7, 1, -1, 0, 1'b0};
    run_cmd(r);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
